// File: rtl/result_tx_scheduler_if.sv
// result_tx_scheduler_if: bundles the job-request and UART handshake signals of
// result_tx_scheduler.
//   load        host -> scheduler   start-of-job request
//   result      host -> scheduler   NUM_BYTES*BYTE_W result vector
//   byte_count  host -> scheduler   number of bytes requested
//   tx_busy     UART -> scheduler   transmitter busy
//   tx_start    scheduler -> UART   one-cycle send request
//   tx_data     scheduler -> UART   byte to send
//   busy        scheduler -> host   job in progress
//   done        scheduler -> host   one-cycle end-of-job pulse
// Modport slave is the scheduler; modport master is the host/UART side.
interface result_tx_scheduler_if #(
  parameter int unsigned NUM_BYTES = 18,
  parameter int unsigned BYTE_W    = 8
);
  logic                        load;
  logic [NUM_BYTES*BYTE_W-1:0] result;
  logic [7:0]                  byte_count;
  logic                        tx_busy;
  logic                        tx_start;
  logic [BYTE_W-1:0]           tx_data;
  logic                        busy;
  logic                        done;

  modport master (
    output load, result, byte_count, tx_busy,
    input  tx_start, tx_data, busy, done
  );

  modport slave (
    input  load, result, byte_count, tx_busy,
    output tx_start, tx_data, busy, done
  );
endinterface

// File: rtl/result_tx_scheduler.sv
// result_tx_scheduler: streams the first n = min(byte_count, NUM_BYTES) bytes of a
// captured result vector to a UART transmitter, LSB byte first, one byte per
// tx_start / tx_busy handshake.
// Ports:
//   bclk  clock
//   rst   synchronous active-high reset (wins over load and tx_busy)
//   bus   result_tx_scheduler_if.slave (load, result, byte_count, tx_busy in;
//         tx_start, tx_data, busy, done out)
// Optional feature: define RESULT_TX_HEADER_EN to send a header byte equal to n
// ahead of data byte 0 (with n = 0 only the header goes out).
// All outputs are registered.
module result_tx_scheduler #(
  parameter int unsigned NUM_BYTES = 18,
  parameter int unsigned BYTE_W    = 8
) (
  input logic                  bclk,
  input logic                  rst,
  result_tx_scheduler_if.slave bus
);

  localparam int unsigned VecW     = NUM_BYTES * BYTE_W;
  localparam logic [7:0]  MaxBytes = 8'(NUM_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StFinish
  } state_e;

  state_e            state_q;
  logic [VecW-1:0]   shadow_q;   // shifted right one byte per sent byte
  logic [7:0]        n_q;
  logic [7:0]        index_q;
  logic              tx_start_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              busy_q;
  logic              done_q;
`ifdef RESULT_TX_HEADER_EN
  logic              hdr_q;      // header byte still to be sent
`endif

  logic [7:0]        n_load;
  logic [BYTE_W-1:0] issue_byte;

  assign n_load = (bus.byte_count > MaxBytes) ? MaxBytes : bus.byte_count;

`ifdef RESULT_TX_HEADER_EN
  assign issue_byte = hdr_q ? BYTE_W'(n_q) : shadow_q[BYTE_W-1:0];
`else
  assign issue_byte = shadow_q[BYTE_W-1:0];
`endif

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      n_q        <= '0;
      index_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESULT_TX_HEADER_EN
      hdr_q      <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          // done_q is still high in the first IDLE cycle; a load there is dropped.
          if (bus.load && !done_q) begin
            shadow_q <= bus.result;
            n_q      <= n_load;
            index_q  <= '0;
            busy_q   <= 1'b1;
`ifdef RESULT_TX_HEADER_EN
            hdr_q    <= 1'b1;
            state_q  <= StIssue;
`else
            state_q  <= (n_load == 8'd0) ? StFinish : StIssue;
`endif
          end
        end
        StIssue: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= issue_byte;
            state_q    <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (bus.tx_busy) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (!bus.tx_busy) begin
`ifdef RESULT_TX_HEADER_EN
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= (n_q == 8'd0) ? StFinish : StIssue;
            end else
`endif
            begin
              index_q  <= index_q + 8'd1;
              shadow_q <= shadow_q >> BYTE_W;
              state_q  <= (index_q + 8'd1 == n_q) ? StFinish : StIssue;
            end
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
